dmem_responder: RTL and testbench

- Data-memory responder serving load/store requests issued by the pipeline memory stage.
- Holds a word-addressed storage array behind a valid/ready request handshake with a programmable access latency. Returns one response per request: read data or a write acknowledge.
- busy_out lets hazard logic stall the pipeline while an access is in flight.
- Sits between the memory stage and the data store. It replaces the single-cycle dmem when multi-cycle memory timing is modelled.

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline memory stage.
// Word-addressed storage behind a valid/ready request handshake. Each accepted request gets
// exactly one response after a fixed, programmable latency.
//
// Ports:
//   clk_in         clock, all state on rising edge
//   rst_n_in       asynchronous active-low reset
//   req_valid_in   request present this cycle
//   we_in / re_in  store / load request (store wins when both are set)
//   address_in     byte address; word index = address[INDEX+1:2], upper bits ignored
//   data_in        store data
//   req_ready_out  high while idle; a request is accepted on that edge
//   rsp_valid_out  one-cycle response pulse
//   data_out       load data during the response, 0 otherwise
//   err_out        misaligned access, qualified by rsp_valid_out
//   busy_out       an access is in flight (accepted, response not yet delivered)
module dmem_responder #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned INDEX   = 5,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             req_valid_in,
    input  logic             we_in,
    input  logic             re_in,
    input  logic [WIDTH-1:0] address_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             req_ready_out,
    output logic             rsp_valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             err_out,
    output logic             busy_out
);

    localparam int unsigned DEPTH = 2 ** INDEX;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             we_q, re_q;
    logic [INDEX+1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic             err_q;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             enter_resp;
    logic             misaligned;
    logic [INDEX-1:0] word_idx;

    // Upper address bits only select aliases of the same word.
    logic unused_addr;
    assign unused_addr = ^address_in[WIDTH-1:INDEX+2];

    assign accept     = (state_q == StIdle) && req_valid_in && (we_in || re_in);
    assign enter_resp = (state_q == StAccess) && (cnt_q == 4'd0);
    assign misaligned = (addr_q[1:0] != 2'b00);
    assign word_idx   = addr_q[INDEX+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StAccess;
                    cnt_d   = CNT_INIT;
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we_in;
                re_q    <= re_in;
                addr_q  <= address_in[INDEX+1:0];
                wdata_q <= data_in;
            end
            // Response data/error live only for the single RESP cycle.
            if (enter_resp) begin
                rdata_q <= (re_q && !we_q && !misaligned) ? mem[word_idx] : '0;
                err_q   <= misaligned;
            end else begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset. A store commits only on the edge entering RESP, so a
    // reset during ACCESS drops it.
    always_ff @(posedge clk_in) begin
        if (enter_resp && we_q && !misaligned) begin
            mem[word_idx] <= wdata_q;
        end
    end

    assign req_ready_out = (state_q == StIdle);
    assign rsp_valid_out = (state_q == StResp);
    assign busy_out      = (state_q != StIdle);
    assign data_out      = rdata_q;
    assign err_out       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int W     = 32;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // sel chooses which instance is driven and observed: 0 -> LATENCY=2, 1 -> LATENCY=1.
    logic         sel = 1'b0;
    logic         req_valid = 1'b0;
    logic         we = 1'b0;
    logic         re = 1'b0;
    logic [W-1:0] addr = '0;
    logic [W-1:0] wdata = '0;

    logic [1:0]   rdy, rsp, err, busy;
    logic [W-1:0] dout0, dout1;

    dmem_responder #(.WIDTH(32), .INDEX(5), .LATENCY(2)) u_lat2 (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .req_valid_in  (req_valid && !sel),
        .we_in         (we),
        .re_in         (re),
        .address_in    (addr),
        .data_in       (wdata),
        .req_ready_out (rdy[0]),
        .rsp_valid_out (rsp[0]),
        .data_out      (dout0),
        .err_out       (err[0]),
        .busy_out      (busy[0])
    );

    dmem_responder #(.WIDTH(32), .INDEX(5), .LATENCY(1)) u_lat1 (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .req_valid_in  (req_valid && sel),
        .we_in         (we),
        .re_in         (re),
        .address_in    (addr),
        .data_in       (wdata),
        .req_ready_out (rdy[1]),
        .rsp_valid_out (rsp[1]),
        .data_out      (dout1),
        .err_out       (err[1]),
        .busy_out      (busy[1])
    );

    logic         o_ready, o_rsp, o_err, o_busy;
    logic [W-1:0] o_data;
    always_comb begin
        o_ready = rdy[sel];
        o_rsp   = rsp[sel];
        o_err   = err[sel];
        o_busy  = busy[sel];
        o_data  = sel ? dout1 : dout0;
    end

    int errors = 0;
    int checks = 0;

    // Reference storage, one per instance.
    logic [W-1:0] model_mem [2][DEPTH];

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input logic s);
        return s ? 1 : 2;
    endfunction

    // Reference behaviour: response data, error flag and the effect on storage.
    task automatic model_apply(input logic w, input logic r, input logic [W-1:0] a,
                               input logic [W-1:0] d, output logic [W-1:0] exp_d,
                               output logic exp_e);
        int idx;
        idx   = int'((a / 4) % DEPTH);
        exp_e = (a % 4) != 0;
        exp_d = '0;
        if (!exp_e) begin
            if (w) model_mem[sel][idx] = d;
            else if (r) exp_d = model_mem[sel][idx];
        end
    endtask

    // Issue one request, wait for its response and check timing/data/error.
    task automatic issue(input string tag, input logic w, input logic r,
                         input logic [W-1:0] a, input logic [W-1:0] d, input logic full);
        int k;
        int low;
        logic [W-1:0] exp_d;
        logic exp_e;
        k = 0;
        @(negedge clk);
        while (!o_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (full) check_eq({tag, "_ready"}, 32'(o_ready), 32'd1);
        req_valid = 1'b1;
        we = w;
        re = r;
        addr = a;
        wdata = d;
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; only the accepted values may matter.
        req_valid = 1'b0;
        we = 1'($urandom);
        re = 1'($urandom);
        addr = $urandom;
        wdata = $urandom;
        model_apply(w, r, a, d, exp_d, exp_e);
        k = 0;
        low = 0;
        do begin
            @(negedge clk);
            k++;
            if (!o_ready) low++;
        end while (!o_rsp && k < 40);
        check_eq({tag, "_lat"}, 32'(k), 32'(lat_of(sel) + 1));
        check_eq({tag, "_data"}, o_data, exp_d);
        check_eq({tag, "_err"}, 32'(o_err), 32'(exp_e));
        if (full) begin
            check_eq({tag, "_rdylow"}, 32'(low), 32'(lat_of(sel) + 1));
            check_eq({tag, "_busy"}, 32'(o_busy), 32'd1);
            @(negedge clk);
            check_eq({tag, "_pulse"}, {o_rsp, o_busy, o_ready}, 3'b001);
            check_eq({tag, "_idle_data"}, o_data, 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] ed;
        logic ee;
        int k;
        int gap;

        // Reset state of both instances.
        #1;
        check_eq("rst_ready", 32'(rdy), 32'b11);
        check_eq("rst_rsp", 32'({rsp, err, busy}), 32'd0);
        check_eq("rst_data", dout0 | dout1, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Give every word a known value in both instances.
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int i = 0; i < DEPTH; i++) issue("init", 1'b1, 1'b0, 32'(i * 4), $urandom, 1'b0);
        end

        // Directed cases on the LATENCY=2 instance.
        sel = 1'b0;
        issue("st10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        issue("ld10", 1'b0, 1'b1, 32'h10, 32'h0, 1'b1);
        issue("st13_mis", 1'b1, 1'b0, 32'h13, 32'h12345678, 1'b1);
        issue("ld10_b", 1'b0, 1'b1, 32'h10, 32'h0, 1'b1);
        issue("ld_mis", 1'b0, 1'b1, 32'h22, 32'h0, 1'b1);
        issue("st84", 1'b1, 1'b0, 32'h84, 32'hA5A5A5A5, 1'b1);
        issue("ld04", 1'b0, 1'b1, 32'h04, 32'h0, 1'b1);

        // Back-to-back loads with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; we = 1'b0; re = 1'b1; addr = 32'h0;
        @(posedge clk);
        #1;
        addr = 32'h4;
        model_apply(1'b0, 1'b1, 32'h0, 32'h0, ed, ee);
        k = 0;
        do begin @(negedge clk); k++; end while (!o_rsp && k < 40);
        check_eq("b2b_lat1", 32'(k), 32'd3);
        check_eq("b2b_data1", o_data, ed);
        gap = 0;
        do begin @(negedge clk); gap++; end while (!o_rsp && gap < 40);
        req_valid = 1'b0;
        model_apply(1'b0, 1'b1, 32'h4, 32'h0, ed, ee);
        check_eq("b2b_gap", 32'(gap), 32'd4);
        check_eq("b2b_data2", o_data, ed);

        // Reset during ACCESS drops the store and the response.
        @(negedge clk);
        req_valid = 1'b1; we = 1'b1; re = 1'b0; addr = 32'h20; wdata = 32'h11111111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst", {o_ready, o_rsp, o_busy, o_err}, 4'b1000);
        check_eq("mid_rst_data", o_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        repeat (4) begin @(negedge clk); if (o_rsp) k++; end
        check_eq("mid_norsp", 32'(k), 32'd0);
        issue("ld20", 1'b0, 1'b1, 32'h20, 32'h0, 1'b1);

        // LATENCY=1 instance: store priority when both enables are set.
        sel = 1'b1;
        issue("both_st8", 1'b1, 1'b1, 32'h8, 32'h5, 1'b1);
        issue("ld8", 1'b0, 1'b1, 32'h8, 32'h0, 1'b1);

        // Request with neither enable is never accepted.
        @(negedge clk);
        req_valid = 1'b1; we = 1'b0; re = 1'b0; addr = 32'h8;
        k = 0;
        repeat (6) begin @(negedge clk); if (!o_ready || o_rsp || o_busy) k++; end
        req_valid = 1'b0;
        check_eq("noop_ignored", 32'(k), 32'd0);

        // Randomised traffic on both instances.
        for (int n = 0; n < 160; n++) begin
            logic w, r;
            logic [W-1:0] a;
            sel = 1'($urandom);
            w = 1'($urandom);
            r = w ? 1'($urandom) : 1'b1;
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            issue("rnd", w, r, a, $urandom, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
